// File: rtl/stack_host_if_if.sv
//------------------------------------------------------------------------------
// Module   : stack_host_if_if
// Brief    : Command/response and stack-device pin bundle for stack_host_if.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface stack_host_if_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [1:0] rsp_err;
    logic       stk_push;
    logic       stk_pop;
    logic [7:0] stk_bus_out;
    logic       stk_bus_oe;
    logic [7:0] stk_bus_in;
    logic       stk_done;
    logic       stk_empty;
    logic       stk_full;

    // Controller plus device side of the bundle.
    modport master (
        output cmd_valid, cmd_op, cmd_data, stk_bus_in, stk_done, stk_empty, stk_full,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  stk_push, stk_pop, stk_bus_out, stk_bus_oe
    );

    // Host initiator side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, stk_bus_in, stk_done, stk_empty, stk_full,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output stk_push, stk_pop, stk_bus_out, stk_bus_oe
    );
endinterface

`default_nettype wire

// File: rtl/stack_host_if.sv
//------------------------------------------------------------------------------
// Module   : stack_host_if
// Brief    : Host-side initiator that runs push/pop transactions on the stack device.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module stack_host_if #(
    parameter int TIMEOUT        = 64,
    parameter int POP_SAMPLE_DLY = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    stack_host_if_if.slave io
);

    localparam int          CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [2:0]  DLY_MAX   = 3'(POP_SAMPLE_DLY);
    localparam logic [1:0]  ERR_OK    = 2'b00;
    localparam logic [1:0]  ERR_FULL  = 2'b01;
    localparam logic [1:0]  ERR_EMPTY = 2'b10;
    localparam logic [1:0]  ERR_TMO   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PUSH_SETUP = 3'd1,
        S_REQ        = 3'd2,
        S_ACK_WAIT   = 3'd3,
        S_DONE_WAIT  = 3'd4,
        S_SAMPLE     = 3'd5,
        S_RESP       = 3'd6
    } state_t;

    state_t           state_q;
    logic             op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       dly_q;
    logic             cmd_ready_q;
    logic             rsp_valid_q;
    logic [7:0]       rsp_data_q;
    logic [1:0]       rsp_err_q;
    logic             push_q;
    logic             pop_q;
    logic             oe_q;
    logic [7:0]       bus_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= 1'b0;
            cnt_q       <= '0;
            dly_q       <= 3'd0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= ERR_OK;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            oe_q        <= 1'b0;
            bus_out_q   <= 8'h00;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (io.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        op_q        <= io.cmd_op;
                        // Device flags only matter at the moment of acceptance.
                        if (!io.cmd_op && io.stk_full) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= ERR_FULL;
                            rsp_data_q  <= 8'h00;
                        end else if (io.cmd_op && io.stk_empty) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= ERR_EMPTY;
                            rsp_data_q  <= 8'h00;
                        end else if (!io.cmd_op) begin
                            bus_out_q <= io.cmd_data;
                            oe_q      <= 1'b1;
                            state_q   <= S_PUSH_SETUP;
                        end else begin
                            pop_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_PUSH_SETUP: begin
                    push_q  <= 1'b1;
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    cnt_q   <= '0;
                    state_q <= S_ACK_WAIT;
                end
                S_ACK_WAIT: begin
                    if (!io.stk_done) begin
                        push_q  <= 1'b0;
                        pop_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_DONE_WAIT;
                    end else if (cnt_q == CNT_MAX) begin
                        push_q      <= 1'b0;
                        pop_q       <= 1'b0;
                        oe_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= ERR_TMO;
                        rsp_data_q  <= 8'h00;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE_WAIT: begin
                    if (io.stk_done) begin
                        if (!op_q) begin
                            oe_q        <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= ERR_OK;
                            rsp_data_q  <= 8'h00;
                            state_q     <= S_RESP;
                        end else begin
                            dly_q   <= 3'd0;
                            state_q <= S_SAMPLE;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        oe_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= ERR_TMO;
                        rsp_data_q  <= 8'h00;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    // Gives the device's bus driver time to settle after done.
                    if (dly_q == DLY_MAX) begin
                        rsp_data_q  <= io.stk_bus_in;
                        rsp_err_q   <= ERR_OK;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        dly_q <= dly_q + 3'd1;
                    end
                end
                S_RESP: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    push_q      <= 1'b0;
                    pop_q       <= 1'b0;
                    oe_q        <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign io.cmd_ready   = cmd_ready_q;
    assign io.rsp_valid   = rsp_valid_q;
    assign io.rsp_data    = rsp_data_q;
    assign io.rsp_err     = rsp_err_q;
    assign io.stk_push    = push_q;
    assign io.stk_pop     = pop_q;
    assign io.stk_bus_oe  = oe_q;
    assign io.stk_bus_out = bus_out_q;

endmodule

`default_nettype wire

// File: tb/tb_stack_host_if.sv
//------------------------------------------------------------------------------
// Module   : tb_stack_host_if
// Brief    : Directed bench for stack_host_if with a behavioural 16-entry stack device.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_stack_host_if;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    stack_host_if_if ifc ();

    stack_host_if #(.TIMEOUT(64), .POP_SAMPLE_DLY(1)) dut (
        .clk (clk),
        .rst (rst),
        .io  (ifc.slave)
    );

    always #5 clk = ~clk;

    // Behavioural device: done falls one cycle after a strobe, rises one cycle later.
    logic       dev_noack   = 1'b0;
    logic       dev_holdlow = 1'b0;
    logic       force_full  = 1'b0;
    logic       force_empty = 1'b0;
    logic       dev_done;
    logic [4:0] dev_sp;
    logic [7:0] dev_bus;
    logic [7:0] dev_mem [16];
    logic [4:0] dev_spm1;

    assign dev_spm1      = dev_sp - 5'd1;
    assign ifc.stk_done  = dev_done;
    assign ifc.stk_bus_in = dev_bus;
    assign ifc.stk_full  = (dev_sp == 5'd16) | force_full;
    assign ifc.stk_empty = (dev_sp == 5'd0) | force_empty;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dev_done <= 1'b1;
            dev_sp   <= 5'd0;
            dev_bus  <= 8'h00;
        end else if (!dev_done) begin
            if (!dev_holdlow) dev_done <= 1'b1;
        end else if ((ifc.stk_push || ifc.stk_pop) && !dev_noack) begin
            dev_done <= 1'b0;
            if (ifc.stk_push && dev_sp < 5'd16) begin
                dev_mem[dev_sp[3:0]] <= ifc.stk_bus_out;
                dev_sp <= dev_sp + 5'd1;
            end else if (ifc.stk_pop && dev_sp > 5'd0) begin
                dev_bus <= dev_mem[dev_spm1[3:0]];
                dev_sp  <= dev_spm1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (ifc.stk_push || ifc.stk_pop))
            chk("inv_strobe", {30'd0, ifc.stk_push & ifc.stk_pop, ifc.stk_pop & ifc.stk_bus_oe}, 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic op, input logic [7:0] d,
                          output logic [7:0] rd, output logic [1:0] re, output int lat,
                          output logic oe_any, output logic str_any);
        int cyc;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = op;
        ifc.cmd_data  = d;
        oe_any  = ifc.stk_bus_oe;
        str_any = ifc.stk_push | ifc.stk_pop;
        step();
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = ~op;
        ifc.cmd_data  = ~d;
        chk("busy_ready", ifc.cmd_ready, 0);
        cyc = 1;
        while (!ifc.rsp_valid && cyc < 200) begin
            oe_any  |= ifc.stk_bus_oe;
            str_any |= ifc.stk_push | ifc.stk_pop;
            step();
            cyc++;
        end
        oe_any  |= ifc.stk_bus_oe;
        str_any |= ifc.stk_push | ifc.stk_pop;
        rd  = ifc.rsp_data;
        re  = ifc.rsp_err;
        lat = cyc;
        step();
        chk("rsp_pulse", ifc.rsp_valid, 0);
        chk("ready_back", ifc.cmd_ready, 1);
    endtask

    initial begin
        logic [7:0] rd;
        logic [1:0] re;
        int         lat;
        logic       oe_any, str_any, rsp_seen;

        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = 1'b0;
        ifc.cmd_data  = 8'h00;
        step();
        step();
        chk("rst_ready", ifc.cmd_ready, 1);
        chk("rst_rspv",  ifc.rsp_valid, 0);
        chk("rst_rspd",  ifc.rsp_data, 0);
        chk("rst_err",   ifc.rsp_err, 0);
        chk("rst_strb",  {ifc.stk_push, ifc.stk_pop}, 0);
        chk("rst_oe",    ifc.stk_bus_oe, 0);
        chk("rst_bus",   ifc.stk_bus_out, 0);
        rst = 1'b0;
        step();

        // Push 0xA5 with cycle-accurate pin checks.
        ifc.cmd_valid = 1'b1; ifc.cmd_op = 1'b0; ifc.cmd_data = 8'hA5;
        step();
        ifc.cmd_valid = 1'b0; ifc.cmd_data = 8'h00;
        chk("p1_c1_oe", ifc.stk_bus_oe, 1);
        chk("p1_c1_bus", ifc.stk_bus_out, 8'hA5);
        chk("p1_c1_push", ifc.stk_push, 0);
        step();
        chk("p1_c2_push", ifc.stk_push, 1);
        chk("p1_c2_oe", ifc.stk_bus_oe, 1);
        step();
        chk("p1_c3_push", ifc.stk_push, 1);
        step();
        chk("p1_c4_push", ifc.stk_push, 0);
        chk("p1_c4_oe", ifc.stk_bus_oe, 1);
        chk("p1_c4_rspv", ifc.rsp_valid, 0);
        step();
        chk("p1_c5_rspv", ifc.rsp_valid, 1);
        chk("p1_c5_err", ifc.rsp_err, 0);
        chk("p1_c5_data", ifc.rsp_data, 0);
        chk("p1_c5_oe", ifc.stk_bus_oe, 0);
        step();
        chk("p1_c6_rspv", ifc.rsp_valid, 0);
        chk("p1_c6_ready", ifc.cmd_ready, 1);

        // Push 0x3C, then pop it back.
        do_cmd(1'b0, 8'h3C, rd, re, lat, oe_any, str_any);
        chk("p2_err", re, 0);
        chk("p2_lat", lat, 5);
        do_cmd(1'b1, 8'h00, rd, re, lat, oe_any, str_any);
        chk("pop_data", rd, 8'h3C);
        chk("pop_err", re, 0);
        chk("pop_lat", lat, 6);
        chk("pop_oe", oe_any, 0);

        // Flag-rejected commands.
        force_full = 1'b1;
        do_cmd(1'b0, 8'h77, rd, re, lat, oe_any, str_any);
        chk("full_err", re, 2'b01);
        chk("full_lat", lat, 1);
        chk("full_strb", str_any, 0);
        chk("full_oe", oe_any, 0);
        force_full = 1'b0;
        force_empty = 1'b1;
        do_cmd(1'b1, 8'h00, rd, re, lat, oe_any, str_any);
        chk("empty_err", re, 2'b10);
        chk("empty_lat", lat, 1);
        chk("empty_strb", str_any, 0);
        force_empty = 1'b0;

        // Device never acknowledges: timeout 65 cycles after ACK_WAIT entry (cycle 3).
        dev_noack = 1'b1;
        ifc.cmd_valid = 1'b1; ifc.cmd_op = 1'b0; ifc.cmd_data = 8'h11;
        step();
        ifc.cmd_valid = 1'b0;
        repeat (66) step();
        chk("tmo_c67_push", ifc.stk_push, 1);
        chk("tmo_c67_rspv", ifc.rsp_valid, 0);
        step();
        chk("tmo_c68_push", ifc.stk_push, 0);
        chk("tmo_c68_oe", ifc.stk_bus_oe, 0);
        chk("tmo_c68_rspv", ifc.rsp_valid, 1);
        chk("tmo_err", ifc.rsp_err, 2'b11);
        chk("tmo_data", ifc.rsp_data, 0);
        step();
        dev_noack = 1'b0;
        chk("tmo_ready", ifc.cmd_ready, 1);
        do_cmd(1'b0, 8'h22, rd, re, lat, oe_any, str_any);
        chk("post_tmo_err", re, 0);
        chk("post_tmo_lat", lat, 5);
        do_cmd(1'b1, 8'h00, rd, re, lat, oe_any, str_any);
        chk("pop_22", rd, 8'h22);
        do_cmd(1'b1, 8'h00, rd, re, lat, oe_any, str_any);
        chk("pop_a5", rd, 8'hA5);
        do_cmd(1'b1, 8'h00, rd, re, lat, oe_any, str_any);
        chk("pop_dry_err", re, 2'b10);
        chk("pop_dry_data", rd, 0);

        // Reset asserted while a push sits in DONE_WAIT.
        dev_holdlow = 1'b1;
        ifc.cmd_valid = 1'b1; ifc.cmd_op = 1'b0; ifc.cmd_data = 8'h55;
        step();
        ifc.cmd_valid = 1'b0;
        repeat (3) step();
        chk("rstm_pre_oe", ifc.stk_bus_oe, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstm_oe", ifc.stk_bus_oe, 0);
        chk("rstm_push", ifc.stk_push, 0);
        chk("rstm_rspv", ifc.rsp_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        dev_holdlow = 1'b0;
        rsp_seen = 1'b0;
        repeat (8) begin
            step();
            rsp_seen |= ifc.rsp_valid;
        end
        chk("rstm_no_rsp", rsp_seen, 0);
        chk("rstm_ready", ifc.cmd_ready, 1);

        // Fill, overflow, drain, underflow.
        for (int i = 0; i < 16; i++) begin
            do_cmd(1'b0, 8'(i), rd, re, lat, oe_any, str_any);
            chk("fill_err", re, 0);
        end
        do_cmd(1'b0, 8'hEE, rd, re, lat, oe_any, str_any);
        chk("over_err", re, 2'b01);
        chk("over_strb", str_any, 0);
        for (int i = 0; i < 16; i++) begin
            do_cmd(1'b1, 8'h00, rd, re, lat, oe_any, str_any);
            chk("drain_data", rd, 32'(15 - i));
            chk("drain_lat", lat, 6);
        end
        do_cmd(1'b1, 8'h00, rd, re, lat, oe_any, str_any);
        chk("under_err", re, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
